// File: rtl/parking_sensor_decoder.sv
// Parking-gate two-beam passage decoder.
// Synchronizes and debounces two active-low beam sensors, then tracks the
// order in which the beams are blocked and cleared. The outer beam is A and
// the inner beam is B. It reports complete entries, complete exits and
// illegal sequences as single-cycle pulses.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   reset      asynchronous active-low reset
//   sensor_a   raw outer-beam sensor, active-low (0 = blocked), async to clk
//   sensor_b   raw inner-beam sensor, active-low (0 = blocked), async to clk
//   a_blocked  debounced beam A state (1 = blocked)
//   b_blocked  debounced beam B state (1 = blocked)
//   car_enter  one-cycle pulse per completed A->B passage
//   car_exit   one-cycle pulse per completed B->A passage
//   seq_error  one-cycle pulse on an illegal beam sequence
module parking_sensor_decoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_a,
  input  logic sensor_b,
  output logic a_blocked,
  output logic b_blocked,
  output logic car_enter,
  output logic car_exit,
  output logic seq_error
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned NUM_SN = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    ENT_A,
    ENT_AB,
    ENT_B,
    EXT_B,
    EXT_AB,
    EXT_A,
    WAIT_CLR
  } state_t;

  // Index 0 is sensor A, index 1 is sensor B.
  logic [NUM_SN-1:0] sync1;
  logic [NUM_SN-1:0] sync2;
  logic [NUM_SN-1:0] deb;
  logic [CNT_W-1:0]  cnt [NUM_SN];

  state_t state;
  state_t state_nxt;
  logic   enter_nxt;
  logic   exit_nxt;
  logic   error_nxt;
  logic [1:0] ab;

  // Two-flop synchronizer. Flops reset to the idle (unblocked) raw level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {sensor_b, sensor_a};
      sync2 <= sync1;
    end
  end

  // Debounce: count consecutive cycles where the synchronized level disagrees
  // with the debounced level, and flip once the count would reach the limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb <= '0;
      for (int i = 0; i < NUM_SN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SN; i++) begin
        if (!sync2[i] != deb[i]) begin
          if (cnt[i] == CNT_LAST) begin
            deb[i] <= ~deb[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign a_blocked = deb[0];
  assign b_blocked = deb[1];
  assign ab        = {deb[0], deb[1]};

  // Decode state register and registered event pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      car_enter <= 1'b0;
      car_exit  <= 1'b0;
      seq_error <= 1'b0;
    end else begin
      state     <= state_nxt;
      car_enter <= enter_nxt;
      car_exit  <= exit_nxt;
      seq_error <= error_nxt;
    end
  end

  // Next-state decode on the debounced pair {a, b}. Simultaneous changes of
  // both beams are judged as the combined pair only.
  always_comb begin
    state_nxt = state;
    enter_nxt = 1'b0;
    exit_nxt  = 1'b0;
    error_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        case (ab)
          2'b10:   state_nxt = ENT_A;
          2'b01:   state_nxt = EXT_B;
          2'b11:   begin state_nxt = WAIT_CLR; error_nxt = 1'b1; end
          default: state_nxt = IDLE;
        endcase
      end
      ENT_A: begin
        case (ab)
          2'b11:   state_nxt = ENT_AB;
          2'b00:   state_nxt = IDLE;
          2'b01:   begin state_nxt = WAIT_CLR; error_nxt = 1'b1; end
          default: state_nxt = ENT_A;
        endcase
      end
      ENT_AB: begin
        case (ab)
          2'b01:   state_nxt = ENT_B;
          2'b10:   state_nxt = ENT_A;
          2'b00:   begin state_nxt = IDLE; error_nxt = 1'b1; end
          default: state_nxt = ENT_AB;
        endcase
      end
      ENT_B: begin
        case (ab)
          2'b00:   begin state_nxt = IDLE; enter_nxt = 1'b1; end
          2'b11:   state_nxt = ENT_AB;
          2'b10:   begin state_nxt = WAIT_CLR; error_nxt = 1'b1; end
          default: state_nxt = ENT_B;
        endcase
      end
      EXT_B: begin
        case (ab)
          2'b11:   state_nxt = EXT_AB;
          2'b00:   state_nxt = IDLE;
          2'b10:   begin state_nxt = WAIT_CLR; error_nxt = 1'b1; end
          default: state_nxt = EXT_B;
        endcase
      end
      EXT_AB: begin
        case (ab)
          2'b10:   state_nxt = EXT_A;
          2'b01:   state_nxt = EXT_B;
          2'b00:   begin state_nxt = IDLE; error_nxt = 1'b1; end
          default: state_nxt = EXT_AB;
        endcase
      end
      EXT_A: begin
        case (ab)
          2'b00:   begin state_nxt = IDLE; exit_nxt = 1'b1; end
          2'b11:   state_nxt = EXT_AB;
          2'b01:   begin state_nxt = WAIT_CLR; error_nxt = 1'b1; end
          default: state_nxt = EXT_A;
        endcase
      end
      WAIT_CLR: begin
        if (ab == 2'b00) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_parking_sensor_decoder.sv
// Bench for parking_sensor_decoder: table-driven passages, hand-written
// latency and reset sequences, and random beam activity checked every cycle
// against a sample-window / passage-pattern reference model.
module tb_parking_sensor_decoder;

  localparam int D = 4;

  logic clk = 1'b0;
  logic reset;
  logic sensor_a;
  logic sensor_b;
  logic a_blocked;
  logic b_blocked;
  logic car_enter;
  logic car_exit;
  logic seq_error;

  int checks = 0;
  int errors = 0;
  int n_enter = 0;
  int n_exit = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  parking_sensor_decoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .sensor_a  (sensor_a),
    .sensor_b  (sensor_b),
    .a_blocked (a_blocked),
    .b_blocked (b_blocked),
    .car_enter (car_enter),
    .car_exit  (car_exit),
    .seq_error (seq_error)
  );

  // ---------------- reference model ----------------
  // ha/hb[k]: blocked level sampled k+1 edges ago. A debounced level flips
  // when the D samples taken 2..D+1 edges ago all disagree with it.
  logic [D:0] ha, hb;
  logic ma, mb, me, mx, mr;
  int phase;  // 0 idle, 1 in passage, 2 waiting for clear
  int dir;    // 0 entry, 1 exit
  int step;   // 1..3 position within the passage pattern

  // Pattern {a,b} at position k of a passage: 00, first, both, second, 00.
  function automatic logic [1:0] pat(input int d, input int k);
    logic [1:0] e;
    case (k)
      1:       e = 2'b10;
      2:       e = 2'b11;
      3:       e = 2'b01;
      default: e = 2'b00;
    endcase
    return (d == 0) ? e : {e[0], e[1]};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ha = '0; hb = '0; ma = 1'b0; mb = 1'b0;
      me = 1'b0; mx = 1'b0; mr = 1'b0;
      phase = 0; dir = 0; step = 0;
    end else begin
      logic [1:0] p;
      p = {ma, mb};
      me = 1'b0; mx = 1'b0; mr = 1'b0;
      if (phase == 0) begin
        if (p == 2'b10) begin phase = 1; dir = 0; step = 1; end
        else if (p == 2'b01) begin phase = 1; dir = 1; step = 1; end
        else if (p == 2'b11) begin phase = 2; mr = 1'b1; end
      end else if (phase == 2) begin
        if (p == 2'b00) phase = 0;
      end else if (p == pat(dir, step + 1)) begin
        if (step == 3) begin
          phase = 0;
          if (dir == 0) me = 1'b1; else mx = 1'b1;
        end else begin
          step = step + 1;
        end
      end else if (p == pat(dir, step - 1)) begin
        if (step == 1) phase = 0; else step = step - 1;
      end else if (p != pat(dir, step)) begin
        mr = 1'b1;
        phase = (p == 2'b00) ? 0 : 2;
      end
      if (ha[D:1] == {D{~ma}}) ma = ~ma;
      if (hb[D:1] == {D{~mb}}) mb = ~mb;
      ha = {ha[D-1:0], ~sensor_a};
      hb = {hb[D-1:0], ~sensor_b};
    end
  end

  // Per-cycle model comparison and pulse counting.
  always @(negedge clk) begin
    checks++;
    if ({a_blocked, b_blocked, car_enter, car_exit, seq_error} !==
        {ma, mb, me, mx, mr}) begin
      errors++;
      $display("FAIL model_cycle t=%0t dut{a,b,en,ex,er}=%b expected=%b", $time,
               {a_blocked, b_blocked, car_enter, car_exit, seq_error},
               {ma, mb, me, mx, mr});
    end
    n_enter += int'(car_enter);
    n_exit  += int'(car_exit);
    n_err   += int'(seq_error);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Edges from now until the selected output equals target (-1 if never).
  task automatic measure(input int sel, input logic target, output int n);
    logic v;
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      case (sel)
        0:       v = a_blocked;
        1:       v = b_blocked;
        2:       v = car_enter;
        default: v = car_exit;
      endcase
      if (v === target) begin n = i; break; end
    end
  endtask

  task automatic hold(input logic sa, input logic sb, input int cyc);
    sensor_a = sa;
    sensor_b = sb;
    repeat (cyc) @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic sa;
    logic sb;
    int   cyc;
    int   en;
    int   ex;
    int   er;
    logic ea;
    logic eb;
  } row_t;

  row_t rows[$];

  function automatic void add(input logic sa, input logic sb, input int cyc,
                              input int en, input int ex, input int er,
                              input logic ea, input logic eb);
    row_t r;
    r.sa = sa; r.sb = sb; r.cyc = cyc; r.en = en; r.ex = ex; r.er = er;
    r.ea = ea; r.eb = eb;
    rows.push_back(r);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int e0, x0, r0, n;

    // entry
    add(0, 1, 10, 0, 0, 0, 1, 0);
    add(0, 0, 10, 0, 0, 0, 1, 1);
    add(1, 0, 10, 0, 0, 0, 0, 1);
    add(1, 1, 10, 1, 0, 0, 0, 0);
    // exit
    add(1, 0, 10, 0, 0, 0, 0, 1);
    add(0, 0, 10, 0, 0, 0, 1, 1);
    add(0, 1, 10, 0, 0, 0, 1, 0);
    add(1, 1, 10, 0, 1, 0, 0, 0);
    // glitch on A
    add(0, 1,  3, 0, 0, 0, 0, 0);
    add(1, 1, 10, 0, 0, 0, 0, 0);
    // back-out
    add(0, 1, 10, 0, 0, 0, 1, 0);
    add(1, 1, 10, 0, 0, 0, 0, 0);
    // reversal ENT_AB -> ENT_A -> IDLE
    add(0, 1, 10, 0, 0, 0, 1, 0);
    add(0, 0, 10, 0, 0, 0, 1, 1);
    add(0, 1, 10, 0, 0, 0, 1, 0);
    add(1, 1, 10, 0, 0, 0, 0, 0);
    // both beams at once from idle, partial release, then a fresh entry
    add(0, 0, 10, 0, 0, 1, 1, 1);
    add(0, 1, 10, 0, 0, 0, 1, 0);
    add(1, 1, 10, 0, 0, 0, 0, 0);
    add(0, 1, 10, 0, 0, 0, 1, 0);
    add(0, 0, 10, 0, 0, 0, 1, 1);
    add(1, 0, 10, 0, 0, 0, 0, 1);
    add(1, 1, 10, 1, 0, 0, 0, 0);

    sensor_a = 1'b1;
    sensor_b = 1'b1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs",
          int'({a_blocked, b_blocked, car_enter, car_exit, seq_error}), 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;

    // table-driven passages
    foreach (rows[i]) begin
      e0 = n_enter; x0 = n_exit; r0 = n_err;
      hold(rows[i].sa, rows[i].sb, rows[i].cyc);
      check($sformatf("row%0d_enter", i), n_enter - e0, rows[i].en);
      check($sformatf("row%0d_exit", i), n_exit - x0, rows[i].ex);
      check($sformatf("row%0d_err", i), n_err - r0, rows[i].er);
      check($sformatf("row%0d_a_blocked", i), int'(a_blocked), int'(rows[i].ea));
      check($sformatf("row%0d_b_blocked", i), int'(b_blocked), int'(rows[i].eb));
    end

    // latency: raw change to debounced output, final release to car_enter
    sensor_a = 1'b0;
    measure(0, 1'b1, n);
    check("lat_a_blocked", n, D + 2);
    hold(0, 0, 10);
    hold(1, 0, 10);
    e0 = n_enter;
    sensor_b = 1'b1;
    measure(2, 1'b1, n);
    check("lat_car_enter", n, D + 3);
    hold(1, 1, 10);
    check("lat_enter_count", n_enter - e0, 1);

    // reset while in ENT_B; B still blocked after release is debounced afresh
    hold(0, 1, 10);
    hold(0, 0, 10);
    hold(1, 0, 10);
    e0 = n_enter; x0 = n_exit; r0 = n_err;
    reset = 1'b0;
    #1;
    check("midop_reset_outputs",
          int'({a_blocked, b_blocked, car_enter, car_exit, seq_error}), 0);
    @(posedge clk); #2;
    reset = 1'b1;
    measure(1, 1'b1, n);
    check("post_reset_b_lat", n, D + 2);
    hold(1, 1, 15);
    check("midop_enter", n_enter - e0, 0);
    check("midop_exit", n_exit - x0, 0);
    check("midop_err", n_err - r0, 0);

    // random activity, with occasional reset pulses
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b0;
        @(negedge clk); #1;
        reset = 1'b1;
      end
      hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           int'($urandom_range(1, 12)));
    end
    hold(1, 1, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/parking_sensor_decoder.md
PARKING_SENSOR_DECODER -- requirements
Module: parking_sensor_decoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, legal range 1..255: consecutive cycles a synchronized sensor level must hold before its debounced state changes.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 sensor_a  input  1  raw outer-beam sensor, active-low (0 = beam blocked), asynchronous to clk.
REQ-005 sensor_b  input  1  raw inner-beam sensor, active-low (0 = beam blocked), asynchronous to clk.
REQ-006 a_blocked  output  1  debounced sensor A state, active-high (1 = blocked).
REQ-007 b_blocked  output  1  debounced sensor B state, active-high (1 = blocked).
REQ-008 car_enter  output  1  one-cycle pulse: one complete A->B passage; drives the occupancy counter's increment.
REQ-009 car_exit  output  1  one-cycle pulse: one complete B->A passage; drives the occupancy counter's decrement.
REQ-010 seq_error  output  1  one-cycle pulse: illegal sensor sequence detected.

Function
REQ-011 Each sensor SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Per-sensor debounce: 8-bit counter increments while synchronized level differs from debounced level and clears to 0 when they agree; on the edge where it would reach DEBOUNCE_CYCLES the debounced level SHALL toggle and the counter SHALL clear.
REQ-013 Raw change held stable SHALL appear on a_blocked/b_blocked exactly DEBOUNCE_CYCLES+2 rising edges after first being sampled; glitches shorter than DEBOUNCE_CYCLES cycles SHALL NOT appear.
REQ-014 Decode FSM states: IDLE, ENT_A, ENT_AB, ENT_B, EXT_B, EXT_AB, EXT_A, WAIT_CLR; inputs are the debounced a, b (1 = blocked).
REQ-015 IDLE: a&!b -> ENT_A; !a&b -> EXT_B; a&b -> WAIT_CLR + seq_error; !a&!b stay.
REQ-016 ENT_A: a&b -> ENT_AB; !a&!b -> IDLE (backed out, no pulse); !a&b -> WAIT_CLR + seq_error; else stay.
REQ-017 ENT_AB: !a&b -> ENT_B; a&!b -> ENT_A (reversing); !a&!b -> IDLE + seq_error; else stay.
REQ-018 ENT_B: !a&!b -> IDLE + car_enter; a&b -> ENT_AB; a&!b -> WAIT_CLR + seq_error; else stay.
REQ-019 EXT_B, EXT_AB, EXT_A SHALL mirror REQ-016..018 with a and b swapped; EXT_A with !a&!b -> IDLE + car_exit.
REQ-020 WAIT_CLR: stay until !a&!b, then -> IDLE; no pulses emitted.
REQ-021 car_enter, car_exit, seq_error SHALL be registered, high for exactly one cycle, asserted in the cycle after the transition edge; at most one of the three is high in any cycle.
REQ-022 End-to-end latency: raw release of the final sensor to car_enter/car_exit high SHALL be DEBOUNCE_CYCLES+3 edges (7 at default).
REQ-023 Both debounced sensors changing on the same edge SHALL be evaluated as the combined (a,b) pair per the tables above; no intermediate state is inferred.

Reset
REQ-024 Reset asserted (reset=0) SHALL immediately force: synchronizer flops 1, debounced state unblocked, counters 0, FSM IDLE, a_blocked=b_blocked=car_enter=car_exit=seq_error=0.
REQ-025 Reset asserted mid-passage SHALL discard the passage; no pulse after release.
REQ-026 After reset release, sensors already held blocked SHALL be debounced normally (REQ-013) and then treated per REQ-015.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 Entry: a=0, then b=0, a=1, b=1, each held 10 cycles -> exactly one car_enter pulse 7 edges after b returns to 1; no car_exit, no seq_error.
REQ-028 Exit: b=0, a=0, b=1, a=1, 10 cycles each -> exactly one car_exit pulse; a_blocked/b_blocked follow each raw change 6 edges later.
REQ-029 Glitch: a=0 for 3 cycles then 1 -> a_blocked stays 0, no pulses, FSM remains IDLE.
REQ-030 Back-out: a=0 10 cycles, a=1 -> FSM returns to IDLE, no pulses; reversal ENT_AB->ENT_A->IDLE likewise silent.
REQ-031 Illegal: a=0 and b=0 asserted same cycle from idle -> one seq_error pulse, no further pulses until both released and a fresh legal sequence completes.
REQ-032 Reset mid-op: reset=0 one cycle while in ENT_B -> all outputs 0 immediately; completing the sequence afterwards yields no car_enter.
